psg_wave_fetch_ctrl: RTL and testbench

Wave-table fetch controller for the four-voice PSG. It takes per-voice wave-sample fetch requests from the note generator and round-robins them onto a single WISHBONE master read port. It returns each 12-bit sample to the requesting voice with a one-cycle grant pulse. A bus timeout guarantees that no voice can stall the channel-multiplexing sequence.

---
 rtl/psg_pkg.sv | 26 ++
 rtl/psg_rr_pick.sv | 23 ++
 rtl/psg_wave_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_psg_wave_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared types and address-field layout for the PSG wave-fetch path.
package psg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_BUS  = 2'd2
  } state_t;

  localparam int NVOICE    = 4;
  localparam int WAVE_W    = 12;
  localparam int ADR_W     = 64;
  localparam int BASE_W    = 34;
  localparam int BASE_LSB  = 14;
  localparam int VOICE_LSB = 12;
  localparam int IDX_LSB   = 1;
  localparam int IDX_W     = VOICE_LSB - IDX_LSB;

  // Sample address: base page, voice sub-table, halfword-aligned index.
  function automatic logic [ADR_W-1:0] wave_adr(input logic [BASE_W-1:0] base,
                                                input logic [1:0]        voice,
                                                input logic [IDX_W-1:0]  idx);
    return (ADR_W'(base) << BASE_LSB) | (ADR_W'(voice) << VOICE_LSB) | (ADR_W'(idx) << IDX_LSB);
  endfunction

endpackage

// File: rtl/psg_rr_pick.sv
// Combinational 4-way round-robin picker: first eligible voice after ptr, wrapping.
module psg_rr_pick
  import psg_pkg::*;
(
  input  logic [NVOICE-1:0] eligible,
  input  logic [1:0]        ptr,
  output logic              valid,
  output logic [1:0]        sel
);

  always_comb begin
    valid = 1'b0;
    sel   = ptr;
    // Offset NVOICE wraps to ptr itself, so the last winner ranks lowest.
    for (int i = 1; i <= NVOICE; i++) begin
      if (!valid && eligible[ptr + 2'(i)]) begin
        valid = 1'b1;
        sel   = ptr + 2'(i);
      end
    end
  end

endmodule

// File: rtl/psg_wave_fetch_ctrl.sv
// Round-robins per-voice wave-sample fetches onto one WISHBONE read master,
// with a bus timeout so a dead slave cannot stall the voice sequence.
module psg_wave_fetch_ctrl
  import psg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NVOICE-1:0]      req_i,
  input  logic [NVOICE*WAVE_W-1:0] idx_i,
  input  logic [BASE_W-1:0]      base_i,
  output logic [NVOICE-1:0]      gnt_o,
  output logic [WAVE_W-1:0]      wave_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   m_cyc_o,
  output logic                   m_stb_o,
  output logic                   m_we_o,
  output logic [1:0]             m_sel_o,
  output logic [ADR_W-1:0]       m_adr_o,
  input  logic                   m_ack_i,
  input  logic [WAVE_W-1:0]      m_dat_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state, state_d;
  logic [1:0]           ptr, ptr_d;
  logic [1:0]           voice, voice_d;
  logic [7:0]           cnt, cnt_d;
  logic [NVOICE-1:0]    gnt_d;
  logic [WAVE_W-1:0]    wave_d;
  logic                 err_d, busy_d, cyc_d;
  logic [ADR_W-1:0]     adr_d;

  logic [NVOICE-1:0]    eligible;
  logic                 pick_valid;
  logic [1:0]           pick_sel;
  logic [IDX_W-1:0]     idx_hi;

  // A voice whose grant is pulsing right now has not yet dropped its request.
  assign eligible = req_i & ~gnt_o;
  assign idx_hi   = idx_i[int'(pick_sel)*WAVE_W + IDX_LSB +: IDX_W];

  psg_rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (pick_valid),
    .sel      (pick_sel)
  );

  assign m_stb_o = m_cyc_o;
  assign m_we_o  = 1'b0;
  assign m_sel_o = {2{m_cyc_o}};

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    voice_d = voice;
    cnt_d   = cnt;
    gnt_d   = '0;
    wave_d  = wave_o;
    err_d   = 1'b0;
    cyc_d   = m_cyc_o;
    adr_d   = m_adr_o;
    unique case (state)
      ST_IDLE: begin
        if (|eligible) state_d = ST_ARB;
      end
      ST_ARB: begin
        cnt_d = '0;
        if (pick_valid) begin
          voice_d = pick_sel;
          adr_d   = wave_adr(base_i, pick_sel, idx_hi);
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        cnt_d = cnt + 8'd1;
        // Ack takes precedence over a timeout landing in the same cycle.
        if (m_ack_i) begin
          wave_d  = m_dat_i;
          gnt_d   = NVOICE'(1) << voice;
          ptr_d   = voice;
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt == TMO_LAST) begin
          wave_d  = '0;
          gnt_d   = NVOICE'(1) << voice;
          err_d   = 1'b1;
          ptr_d   = voice;
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      ptr     <= 2'd3;
      voice   <= 2'd0;
      cnt     <= '0;
      gnt_o   <= '0;
      wave_o  <= '0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      m_cyc_o <= 1'b0;
      m_adr_o <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      voice   <= voice_d;
      cnt     <= cnt_d;
      gnt_o   <= gnt_d;
      wave_o  <= wave_d;
      err_o   <= err_d;
      busy_o  <= busy_d;
      m_cyc_o <= cyc_d;
      m_adr_o <= adr_d;
    end
  end

endmodule

// File: tb/tb_psg_wave_fetch_ctrl.sv
// Directed bench for psg_wave_fetch_ctrl: single fetch, rotation, timeout,
// ack/timeout tie, reset abort and withdrawn request.
module tb_psg_wave_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  req_i = '0;
  logic [47:0] idx_i = '0;
  logic [33:0] base_i = '0;
  logic [3:0]  gnt_o;
  logic [11:0] wave_o;
  logic        err_o, busy_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [1:0]  m_sel_o;
  logic [63:0] m_adr_o;
  logic        m_ack_i = 1'b0;
  logic [11:0] m_dat_i = '0;

  int checks = 0;
  int errors = 0;

  // Slave model: acks after slave_wait BUS cycles; manual mode drives ack directly.
  bit slave_en = 1'b1;
  bit manual_ack = 1'b0;
  int slave_wait = 0;
  int wait_cnt = 0;

  logic [3:0] exp_q[$];

  psg_wave_fetch_ctrl #(.TIMEOUT(15)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .idx_i   (idx_i),
    .base_i  (base_i),
    .gnt_o   (gnt_o),
    .wave_o  (wave_o),
    .err_o   (err_o),
    .busy_o  (busy_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_sel_o (m_sel_o),
    .m_adr_o (m_adr_o),
    .m_ack_i (m_ack_i),
    .m_dat_i (m_dat_i)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation hung");
  end

  always @(negedge clk) begin
    if (!slave_en) begin
      m_ack_i = manual_ack;
      wait_cnt = 0;
    end else if (m_cyc_o) begin
      m_ack_i = (wait_cnt == slave_wait);
      wait_cnt++;
    end else begin
      m_ack_i = 1'b0;
      wait_cnt = 0;
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Steps until a grant shows up (bounded); counts cycles and m_cyc_o-high cycles.
  task automatic wait_gnt(output int n, output int cyc_n);
    n = 0;
    cyc_n = 0;
    do begin
      step(1);
      n++;
      if (m_cyc_o) cyc_n++;
    end while (gnt_o == 4'b0000 && n < 60);
  endtask

  initial begin
    int n, c;
    logic [3:0] exp_g;

    // Reset state
    step(2);
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_wave", 64'(wave_o), 64'h0);
    chk("rst_cyc", 64'(m_cyc_o), 64'h0);
    chk("rst_adr", m_adr_o, 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    rst_i = 1'b0;
    step(1);

    // Single fetch, zero-wait slave
    idx_i[11:0] = 12'hABC;
    base_i = 34'h0000000E0;
    slave_wait = 0;
    m_dat_i = 12'h123;
    req_i = 4'b0001;
    step(1);
    chk("t1_busy_arb", 64'(busy_o), 64'h1);
    chk("t1_cyc_arb", 64'(m_cyc_o), 64'h0);
    step(1);
    chk("t1_cyc_bus", 64'(m_cyc_o), 64'h1);
    chk("t1_stb", 64'(m_stb_o), 64'h1);
    chk("t1_sel", 64'(m_sel_o), 64'h3);
    chk("t1_we", 64'(m_we_o), 64'h0);
    chk("t1_adr", m_adr_o, 64'h0000_0000_0038_0ABC);
    chk("t1_gnt_early", 64'(gnt_o), 64'h0);
    step(1);
    chk("t1_gnt", 64'(gnt_o), 64'h1);
    chk("t1_wave", 64'(wave_o), 64'h123);
    chk("t1_err", 64'(err_o), 64'h0);
    req_i = 4'b0000;
    step(1);
    chk("t1_gnt_pulse", 64'(gnt_o), 64'h0);
    chk("t1_idle_cyc", 64'(m_cyc_o), 64'h0);
    step(2);

    // Rotation with all four held, from a fresh reset
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    m_dat_i = 12'h5A5;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    req_i = 4'b1111;
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      wait_gnt(n, c);
      chk("rr_gnt", 64'(gnt_o), 64'(exp_g));
      chk("rr_gap", 64'(n), 64'd3);
    end
    req_i = 4'b0000;
    step(2);

    // Timeout on voice 2, slave never acks
    slave_wait = 1000;
    req_i = 4'b0100;
    wait_gnt(n, c);
    chk("to_cyc_cycles", 64'(c), 64'd15);
    chk("to_gnt", 64'(gnt_o), 64'h4);
    chk("to_err", 64'(err_o), 64'h1);
    chk("to_wave", 64'(wave_o), 64'h0);
    req_i = 4'b0000;
    step(1);
    chk("to_err_pulse", 64'(err_o), 64'h0);
    chk("to_cyc_drop", 64'(m_cyc_o), 64'h0);
    step(1);

    // Ack on the last timeout cycle wins; address held despite input changes
    slave_wait = 14;
    m_dat_i = 12'h7E1;
    idx_i[47:36] = 12'h0F3;
    base_i = 34'h3_0000_0001;
    req_i = 4'b1000;
    step(2);
    chk("tie_adr", m_adr_o, 64'h0000_C000_0000_70F2);
    idx_i[47:36] = 12'h000;
    base_i = 34'h0;
    wait_gnt(n, c);
    chk("tie_cyc_cycles", 64'(c + 1), 64'd15);
    chk("tie_gnt", 64'(gnt_o), 64'h8);
    chk("tie_wave", 64'(wave_o), 64'h7E1);
    chk("tie_err", 64'(err_o), 64'h0);
    chk("tie_adr_held", m_adr_o, 64'h0000_C000_0000_70F2);
    req_i = 4'b0000;
    step(2);

    // Reset during a 3-wait access to voice 2
    slave_wait = 3;
    req_i = 4'b0100;
    step(3);
    chk("ra_cyc_pre", 64'(m_cyc_o), 64'h1);
    rst_i = 1'b1;
    req_i = 4'b0000;
    step(1);
    rst_i = 1'b0;
    chk("ra_cyc", 64'(m_cyc_o), 64'h0);
    chk("ra_gnt", 64'(gnt_o), 64'h0);
    slave_en = 1'b0;
    manual_ack = 1'b1;
    step(2);
    chk("ra_late_gnt", 64'(gnt_o), 64'h0);
    chk("ra_late_wave", 64'(wave_o), 64'h0);
    chk("ra_late_busy", 64'(busy_o), 64'h0);
    manual_ack = 1'b0;
    step(1);
    slave_en = 1'b1;
    slave_wait = 0;
    m_dat_i = 12'h2C4;
    req_i = 4'b0101;
    wait_gnt(n, c);
    chk("ra_first", 64'(gnt_o), 64'h1);
    chk("ra_first_wave", 64'(wave_o), 64'h2C4);
    wait_gnt(n, c);
    chk("ra_second", 64'(gnt_o), 64'h4);
    req_i = 4'b0000;
    step(2);

    // Voice 1 withdraws during ARB: no bus cycle, pointer stays on voice 2
    req_i = 4'b0010;
    step(1);
    chk("wd_busy_arb", 64'(busy_o), 64'h1);
    req_i = 4'b0000;
    step(1);
    chk("wd_cyc", 64'(m_cyc_o), 64'h0);
    chk("wd_busy", 64'(busy_o), 64'h0);
    step(2);
    chk("wd_cyc_later", 64'(m_cyc_o), 64'h0);
    chk("wd_gnt", 64'(gnt_o), 64'h0);
    req_i = 4'b0110;
    wait_gnt(n, c);
    chk("wd_ptr_first", 64'(gnt_o), 64'h2);
    wait_gnt(n, c);
    chk("wd_ptr_second", 64'(gnt_o), 64'h4);
    req_i = 4'b0000;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
